reg_file: RTL and testbench

- General-purpose register file directly upstream of the ALU; supplies the ALU's A and B operands and accepts the ALU result and zero flag back.
- Two combinational read ports and one synchronous write port.
- A registered zero flag holds the ALU Zero output for later branch decisions.

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/flag_reg.sv | 18 +
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the ALU-side register file: address width, register count
// and the register address type.
package reg_file_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_COUNT  = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_pkg

// File: rtl/flag_reg.sv
// Single-bit status flag with a capture enable and an asynchronous active-high clear.
// It holds the ALU zero flag and is reusable for carry or parity flags.
module flag_reg (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    input  logic D,
    output logic Q
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Q <= 1'b0;
        else if (En)
            Q <= D;
    end

endmodule : flag_reg

// File: rtl/reg_file.sv
// Register file feeding the ALU: two combinational read ports, one synchronous write port
// and a registered zero flag. Define REG_FILE_BYPASS_EN to forward same-cycle write data.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int W = 8,
    parameter int D = REG_ADDR_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [D-1:0] RdAddrA,
    input  logic [D-1:0] RdAddrB,
    output logic [W-1:0] DatA,
    output logic [W-1:0] DatB,
    input  logic         WrEn,
    input  logic [D-1:0] WrAddr,
    input  logic [W-1:0] WrDat,
    input  logic         FlagEn,
    input  logic         ZeroIn,
    output logic         ZeroFlag
);

    localparam int N = 1 << D;

    logic [W-1:0] mem [N];

    // Clearing the whole array asynchronously keeps reads at 0 for as long as Reset is high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N; i++)
                mem[i] <= '0;
        end else if (WrEn) begin
            mem[WrAddr] <= WrDat;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        DatA = mem[RdAddrA];
        DatB = mem[RdAddrB];
        if (!Reset && WrEn && (WrAddr == RdAddrA))
            DatA = WrDat;
        if (!Reset && WrEn && (WrAddr == RdAddrB))
            DatB = WrDat;
    end
`else
    always_comb begin
        DatA = mem[RdAddrA];
        DatB = mem[RdAddrB];
    end
`endif

    flag_reg u_zero_flag (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (FlagEn),
        .D     (ZeroIn),
        .Q     (ZeroFlag)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read/flag values,
// a monitor pops and compares them at each sample point.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int W = 8;

    typedef struct {
        string      name;
        int         sel;   // 0: DatA, 1: DatB, 2: ZeroFlag
        logic [W-1:0] exp;
    } item_t;

    logic         Clk = 1'b0;
    logic         Reset;
    reg_addr_t    RdAddrA, RdAddrB, WrAddr;
    logic [W-1:0] DatA, DatB, WrDat;
    logic         WrEn, FlagEn, ZeroIn, ZeroFlag;

    item_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    event  check_ev;

    reg_file dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .RdAddrA  (RdAddrA),
        .RdAddrB  (RdAddrB),
        .DatA     (DatA),
        .DatB     (DatB),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrDat    (WrDat),
        .FlagEn   (FlagEn),
        .ZeroIn   (ZeroIn),
        .ZeroFlag (ZeroFlag)
    );

    always #5 Clk = ~Clk;

    // Monitor: drains every queued expectation whenever the stimulus asks for a sample.
    initial begin
        item_t it;
        logic [W-1:0] act;
        forever begin
            @(check_ev);
            while (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                case (it.sel)
                    0:       act = DatA;
                    1:       act = DatB;
                    default: act = {{(W-1){1'b0}}, ZeroFlag};
                endcase
                vectors++;
                if (act !== it.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [W-1:0] e);
        item_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic check_now();
        -> check_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_reg(input reg_addr_t a, input logic [W-1:0] d);
        WrEn   = 1'b1;
        WrAddr = a;
        WrDat  = d;
        tick();
        WrEn   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] alu_out;

        Reset = 1'b1;
        WrEn = 1'b1; WrAddr = 3'd1; WrDat = 8'h99;
        FlagEn = 1'b1; ZeroIn = 1'b1;
        RdAddrA = 3'd1; RdAddrB = 3'd0;
        repeat (2) tick();
        expect_val("rst_data_a", 0, 8'h00);
        expect_val("rst_data_b", 1, 8'h00);
        expect_val("rst_flag", 2, 8'h00);
        check_now();

        Reset = 1'b0; WrEn = 1'b0; FlagEn = 1'b0; ZeroIn = 1'b0;
        tick();
        expect_val("rst_wr_ignored", 0, 8'h00);
        expect_val("rst_flag_ignored", 2, 8'h00);
        check_now();

        // Async reset mid-cycle
        FlagEn = 1'b1; ZeroIn = 1'b1;
        write_reg(3'd3, 8'hA5);
        FlagEn = 1'b0; ZeroIn = 1'b0;
        RdAddrA = 3'd3;
        expect_val("preload_r3", 0, 8'hA5);
        expect_val("preload_flag", 2, 8'h01);
        check_now();
        #1;
        Reset = 1'b1;
        #1;
        expect_val("async_rst_data", 0, 8'h00);
        expect_val("async_rst_flag", 2, 8'h00);
        check_now();
        Reset = 1'b0;
        WrEn = 1'b1; WrAddr = 3'd3; WrDat = 8'h5A;
        #1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0; WrEn = 1'b0;
        #1;
        expect_val("wr_lost_in_reset", 0, 8'h00);
        check_now();

        // Write then read, then hold with WrEn low
        RdAddrA = 3'd5; RdAddrB = 3'd5;
        write_reg(3'd5, 8'h3C);
        WrDat = 8'hFF;
        expect_val("wr_rd_a", 0, 8'h3C);
        expect_val("wr_rd_b", 1, 8'h3C);
        check_now();
        tick();
        expect_val("wr_en_low_hold", 0, 8'h3C);
        check_now();

        // Same-cycle write and read
        write_reg(3'd2, 8'h11);
        WrEn = 1'b1; WrAddr = 3'd2; WrDat = 8'h22;
        RdAddrA = 3'd2; RdAddrB = 3'd5;
        #1;
`ifdef REG_FILE_BYPASS_EN
        expect_val("same_cyc_before", 0, 8'h22);
`else
        expect_val("same_cyc_before", 0, 8'h11);
`endif
        expect_val("same_cyc_other", 1, 8'h3C);
        check_now();
        tick();
        WrEn = 1'b0;
        expect_val("same_cyc_after", 0, 8'h22);
        check_now();

        // All addresses, pairwise readback
        for (int i = 0; i < REG_COUNT; i++)
            write_reg(reg_addr_t'(i), 8'(i * 8'h11));
        for (int i = 0; i < REG_COUNT; i++) begin
            RdAddrA = reg_addr_t'(i);
            RdAddrB = reg_addr_t'(REG_COUNT - 1 - i);
            #1;
            expect_val($sformatf("all_a%0d", i), 0, 8'(i * 8'h11));
            expect_val($sformatf("all_b%0d", REG_COUNT - 1 - i), 1, 8'((REG_COUNT - 1 - i) * 8'h11));
            check_now();
        end

        // Flag capture and hold
        FlagEn = 1'b1; ZeroIn = 1'b1;
        tick();
        FlagEn = 1'b0; ZeroIn = 1'b0;
        expect_val("flag_set", 2, 8'h01);
        check_now();
        tick();
        expect_val("flag_hold", 2, 8'h01);
        check_now();
        FlagEn = 1'b1; ZeroIn = 1'b0;
        tick();
        FlagEn = 1'b0;
        expect_val("flag_clear", 2, 8'h00);
        check_now();

        // ALU loop: SUB r0 - r1 into r2 with flag capture
        write_reg(3'd0, 8'h05);
        write_reg(3'd1, 8'h05);
        RdAddrA = 3'd0; RdAddrB = 3'd1;
        #1;
        alu_out = DatA - DatB;
        WrEn = 1'b1; WrAddr = 3'd2; WrDat = alu_out;
        FlagEn = 1'b1; ZeroIn = (alu_out == '0);
        tick();
        WrEn = 1'b0; FlagEn = 1'b0; ZeroIn = 1'b0;
        RdAddrA = 3'd2;
        #1;
        expect_val("alu_r2", 0, 8'h00);
        expect_val("alu_zero", 2, 8'h01);
        check_now();

        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_file
